// File: rtl/axi_fourchan_tier2_slave_llink.sv
// Slave-side logic-link endpoint: packs four 74-bit AXI channels into one 296-bit word under
// credit flow control on TX, and buffers/splits incoming words through a FWFT FIFO on RX.
module axi_fourchan_tier2_slave_llink #(
  parameter int TX_CREDITS = 4,
  parameter int RX_DEPTH   = 4,
  parameter int CW         = 4
) (
  input  logic         clk_wr,
  input  logic         rst_wr_n,
  input  logic         rx_online,
  input  logic         m_gen2_mode,
  input  logic [73:0]  ch0_tx_data,
  input  logic [73:0]  ch1_tx_data,
  input  logic [73:0]  ch2_tx_data,
  input  logic [73:0]  ch3_tx_data,
  input  logic         user_tx_valid,
  output logic         user_tx_ready,
  output logic [295:0] txfifo_tx_data,
  output logic         txfifo_tx_valid,
  input  logic         rx_credit_return,
  input  logic [295:0] rxfifo_rx_data,
  input  logic         rxfifo_rx_valid,
  output logic [73:0]  ch0_rx_data,
  output logic [73:0]  ch1_rx_data,
  output logic [73:0]  ch2_rx_data,
  output logic [73:0]  ch3_rx_data,
  output logic         user_rx_valid,
  input  logic         user_rx_ready,
  output logic         tx_credit_return,
  output logic         rx_overflow,
  output logic         credit_err
);

  localparam int AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam logic [CW-1:0] CRED_MAX = CW'(TX_CREDITS);
  localparam logic [CW-1:0] CRED_ONE = CW'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(RX_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic {OFFLINE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] credit, credit_nxt;
  logic          cerr_set;
  logic          active, staying, send;

  logic [295:0]  mem [RX_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, push, pop, wr_en;
  logic [295:0]  head;

  assign active  = (state == ACTIVE);
  assign staying = active & rx_online;

  assign user_tx_ready = active && (credit != '0) && !(!m_gen2_mode && txfifo_tx_valid);
  assign send          = user_tx_valid & user_tx_ready;

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      state  <= OFFLINE;
      credit <= '0;
    end else begin
      state  <= state_nxt;
      credit <= credit_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    cerr_set   = 1'b0;
    case (state)
      OFFLINE: begin
        credit_nxt = '0;
        if (rx_online) begin
          state_nxt  = ACTIVE;
          credit_nxt = CRED_MAX;
        end
      end
      ACTIVE: begin
        if (!rx_online) begin
          state_nxt  = OFFLINE;
          credit_nxt = '0;
        end else if (send && !rx_credit_return) begin
          credit_nxt = credit - CRED_ONE;
        end else if (!send && rx_credit_return) begin
          // a return with nothing outstanding is a far-end protocol error
          if (credit == CRED_MAX) cerr_set = 1'b1;
          else                    credit_nxt = credit + CRED_ONE;
        end
      end
      default: state_nxt = OFFLINE;
    endcase
  end

  // A send accepted in the same cycle the link drops is not forwarded.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      txfifo_tx_valid <= 1'b0;
      txfifo_tx_data  <= '0;
      credit_err      <= 1'b0;
    end else begin
      txfifo_tx_valid <= send & staying;
      if (send && staying)
        txfifo_tx_data <= {ch3_tx_data, ch2_tx_data, ch1_tx_data, ch0_tx_data};
      if (cerr_set) credit_err <= 1'b1;
    end
  end

  assign full          = (count == CNT_FULL);
  assign user_rx_valid = (count != '0);
  assign push          = active & rxfifo_rx_valid;
  assign pop           = user_rx_valid & user_rx_ready;
  assign wr_en         = push & (!full | pop);

  always_ff @(posedge clk_wr) begin
    if (wr_en) mem[wr_ptr] <= rxfifo_rx_data;
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      tx_credit_return <= 1'b0;
      rx_overflow      <= 1'b0;
    end else begin
      tx_credit_return <= pop & staying;
      if (push && full && !pop) rx_overflow <= 1'b1;
      if (!staying) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
        if (wr_en && !pop)      count <= count + CNT_ONE;
        else if (!wr_en && pop) count <= count - CNT_ONE;
      end
    end
  end

  assign head        = user_rx_valid ? mem[rd_ptr] : '0;
  assign ch0_rx_data = head[73:0];
  assign ch1_rx_data = head[147:74];
  assign ch2_rx_data = head[221:148];
  assign ch3_rx_data = head[295:222];

endmodule

// File: tb/tb_axi_fourchan_tier2_slave_llink.sv
// Directed bench: per-cycle TX/credit vector table plus hand-written RX FIFO and link-drop sequences.
module tb_axi_fourchan_tier2_slave_llink;

  logic         clk_wr = 1'b0;
  logic         rst_wr_n;
  logic         rx_online, m_gen2_mode;
  logic [73:0]  ch0_tx_data, ch1_tx_data, ch2_tx_data, ch3_tx_data;
  logic         user_tx_valid, user_tx_ready;
  logic [295:0] txfifo_tx_data;
  logic         txfifo_tx_valid;
  logic         rx_credit_return;
  logic [295:0] rxfifo_rx_data;
  logic         rxfifo_rx_valid;
  logic [73:0]  ch0_rx_data, ch1_rx_data, ch2_rx_data, ch3_rx_data;
  logic         user_rx_valid, user_rx_ready;
  logic         tx_credit_return, rx_overflow, credit_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_wr = ~clk_wr;

  axi_fourchan_tier2_slave_llink dut (
    .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .rx_online(rx_online), .m_gen2_mode(m_gen2_mode),
    .ch0_tx_data(ch0_tx_data), .ch1_tx_data(ch1_tx_data), .ch2_tx_data(ch2_tx_data),
    .ch3_tx_data(ch3_tx_data), .user_tx_valid(user_tx_valid), .user_tx_ready(user_tx_ready),
    .txfifo_tx_data(txfifo_tx_data), .txfifo_tx_valid(txfifo_tx_valid),
    .rx_credit_return(rx_credit_return), .rxfifo_rx_data(rxfifo_rx_data),
    .rxfifo_rx_valid(rxfifo_rx_valid), .ch0_rx_data(ch0_rx_data), .ch1_rx_data(ch1_rx_data),
    .ch2_rx_data(ch2_rx_data), .ch3_rx_data(ch3_rx_data), .user_rx_valid(user_rx_valid),
    .user_rx_ready(user_rx_ready), .tx_credit_return(tx_credit_return),
    .rx_overflow(rx_overflow), .credit_err(credit_err)
  );

  typedef struct {
    logic on, g2, tv, cr;
    logic rdy, tval, cerr;
  } vec_t;

  vec_t tbl [22];

  function automatic logic [295:0] mkword(input int i);
    logic [295:0] w;
    for (int k = 0; k < 4; k++)
      w[k*74 +: 74] = {10'(i), 32'(k + 1), 32'hA5A5_0000 + 32'(i)};
    return w;
  endfunction

  task automatic chk(input string name, input logic [295:0] act, input logic [295:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_wr);
    #1;
  endtask

  task automatic set_ch(input logic [295:0] w);
    ch0_tx_data = w[73:0];
    ch1_tx_data = w[147:74];
    ch2_tx_data = w[221:148];
    ch3_tx_data = w[295:222];
  endtask

  function automatic logic [295:0] rx_head();
    return {ch3_rx_data, ch2_rx_data, ch1_rx_data, ch0_rx_data};
  endfunction

  task automatic do_reset();
    rst_wr_n = 1'b0;
    rx_online = 0; m_gen2_mode = 1; user_tx_valid = 0; rx_credit_return = 0;
    rxfifo_rx_valid = 0; rxfifo_rx_data = '0; user_rx_ready = 0;
    set_ch('0);
    repeat (2) @(posedge clk_wr);
    #1 rst_wr_n = 1'b1;
  endtask

  initial begin
    //                on g2 tv cr  rdy tval cerr
    tbl[0]  = '{1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0};
    tbl[1]  = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0};
    tbl[2]  = '{1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0};
    tbl[3]  = '{1'b1,1'b1,1'b1,1'b0, 1'b1,1'b1,1'b0};
    tbl[4]  = '{1'b1,1'b1,1'b1,1'b0, 1'b1,1'b1,1'b0};
    tbl[5]  = '{1'b1,1'b1,1'b1,1'b0, 1'b1,1'b1,1'b0};
    tbl[6]  = '{1'b1,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b0};
    tbl[7]  = '{1'b1,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0};
    tbl[8]  = '{1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0};
    tbl[9]  = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0};
    tbl[10] = '{1'b1,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0};
    tbl[11] = '{1'b1,1'b1,1'b0,1'b1, 1'b1,1'b0,1'b0};
    tbl[12] = '{1'b1,1'b1,1'b0,1'b1, 1'b1,1'b0,1'b0};
    tbl[13] = '{1'b1,1'b1,1'b0,1'b1, 1'b1,1'b0,1'b0};
    tbl[14] = '{1'b1,1'b1,1'b0,1'b1, 1'b1,1'b0,1'b0};
    tbl[15] = '{1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b1};
    tbl[16] = '{1'b1,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b1};
    tbl[17] = '{1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b1};
    tbl[18] = '{1'b1,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b1};
    tbl[19] = '{1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b1};
    tbl[20] = '{1'b1,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b1};
    tbl[21] = '{1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b1};

    // reset state
    do_reset();
    rst_wr_n = 1'b0;
    #1;
    chk("rst_tx_ready", 296'(user_tx_ready), 296'(0));
    chk("rst_tx_valid", 296'(txfifo_tx_valid), 296'(0));
    chk("rst_tx_data", txfifo_tx_data, '0);
    chk("rst_rx_valid", 296'(user_rx_valid), 296'(0));
    chk("rst_rx_data", rx_head(), '0);
    chk("rst_tcr", 296'(tx_credit_return), 296'(0));
    chk("rst_ovf", 296'(rx_overflow), 296'(0));
    chk("rst_cerr", 296'(credit_err), 296'(0));
    step();
    rst_wr_n = 1'b1;

    // credit / gen1-gen2 pacing table
    for (int i = 0; i < 22; i++) begin
      rx_online = tbl[i].on; m_gen2_mode = tbl[i].g2;
      user_tx_valid = tbl[i].tv; rx_credit_return = tbl[i].cr;
      set_ch(mkword(100 + i));
      #1;
      chk($sformatf("tbl%0d_ready", i), 296'(user_tx_ready), 296'(tbl[i].rdy));
      chk($sformatf("tbl%0d_txvalid", i), 296'(txfifo_tx_valid), 296'(tbl[i].tval));
      chk($sformatf("tbl%0d_cerr", i), 296'(credit_err), 296'(tbl[i].cerr));
      step();
    end

    // A: credits exhausted, one return re-opens exactly one send with exact packing
    do_reset();
    rx_online = 1; step();
    user_tx_valid = 1; set_ch(mkword(1));
    repeat (4) step();
    set_ch(mkword(7));
    #1 chk("A_ready_no_credit", 296'(user_tx_ready), 296'(0));
    rx_credit_return = 1; step();
    rx_credit_return = 0;
    #1 chk("A_ready_after_ret", 296'(user_tx_ready), 296'(1));
    step();
    user_tx_valid = 0;
    #1;
    chk("A_txvalid", 296'(txfifo_tx_valid), 296'(1));
    chk("A_txdata", txfifo_tx_data, mkword(7));
    chk("A_ready_empty_again", 296'(user_tx_ready), 296'(0));
    set_ch(mkword(8));
    step();
    chk("A_txvalid_drop", 296'(txfifo_tx_valid), 296'(0));
    chk("A_txdata_hold", txfifo_tx_data, mkword(7));

    // B: 5 pushes into depth-4 FIFO, overflow, in-order drain
    do_reset();
    rx_online = 1; step();
    for (int i = 1; i <= 5; i++) begin
      rxfifo_rx_valid = 1; rxfifo_rx_data = mkword(10 + i);
      if (i == 2) begin
        #1;
        chk("B_fwft_valid", 296'(user_rx_valid), 296'(1));
        chk("B_fwft_data", rx_head(), mkword(11));
      end
      step();
    end
    rxfifo_rx_valid = 0;
    #1;
    chk("B_overflow", 296'(rx_overflow), 296'(1));
    user_rx_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("B_pop%0d", i), rx_head(), mkword(10 + i));
      step();
      chk($sformatf("B_tcr%0d", i), 296'(tx_credit_return), 296'(1));
      #1;
    end
    user_rx_ready = 0;
    chk("B_empty_valid", 296'(user_rx_valid), 296'(0));
    chk("B_empty_data", rx_head(), '0);
    step();
    chk("B_tcr_idle", 296'(tx_credit_return), 296'(0));

    // C: full FIFO with simultaneous push and pop
    do_reset();
    rx_online = 1; step();
    for (int i = 1; i <= 4; i++) begin
      rxfifo_rx_valid = 1; rxfifo_rx_data = mkword(20 + i);
      step();
    end
    rxfifo_rx_data = mkword(25); user_rx_ready = 1;
    #1 chk("C_head_before", rx_head(), mkword(21));
    step();
    rxfifo_rx_valid = 0; user_rx_ready = 0;
    #1;
    chk("C_no_overflow", 296'(rx_overflow), 296'(0));
    chk("C_tcr_pulse", 296'(tx_credit_return), 296'(1));
    step();
    chk("C_tcr_single", 296'(tx_credit_return), 296'(0));
    user_rx_ready = 1;
    for (int i = 2; i <= 5; i++) begin
      #1 chk($sformatf("C_pop%0d", i), rx_head(), mkword(20 + i));
      step();
    end
    user_rx_ready = 0;
    #1 chk("C_count4_then_empty", 296'(user_rx_valid), 296'(0));

    // D: link drop with traffic queued, then re-up reloads full credit
    do_reset();
    rx_online = 1; step();
    user_tx_valid = 1; set_ch(mkword(30));
    repeat (2) step();
    user_tx_valid = 0;
    for (int i = 1; i <= 2; i++) begin
      rxfifo_rx_valid = 1; rxfifo_rx_data = mkword(30 + i);
      step();
    end
    rxfifo_rx_valid = 0;
    #1 chk("D_queued", 296'(user_rx_valid), 296'(1));
    rx_online = 0; step();
    #1;
    chk("D_flushed", 296'(user_rx_valid), 296'(0));
    chk("D_txvalid", 296'(txfifo_tx_valid), 296'(0));
    chk("D_ready_off", 296'(user_tx_ready), 296'(0));
    rxfifo_rx_valid = 1; rxfifo_rx_data = mkword(33); rx_credit_return = 1;
    step();
    rxfifo_rx_valid = 0; rx_credit_return = 0;
    #1;
    chk("D_offline_discard", 296'(user_rx_valid), 296'(0));
    chk("D_offline_no_ovf", 296'(rx_overflow), 296'(0));
    chk("D_offline_no_cerr", 296'(credit_err), 296'(0));
    rx_online = 1; user_tx_valid = 1;
    chk("D_ready_pre_up", 296'(user_tx_ready), 296'(0));
    step();
    for (int i = 1; i <= 4; i++) begin
      #1 chk($sformatf("D_reload_send%0d", i), 296'(user_tx_ready), 296'(1));
      step();
    end
    #1 chk("D_reload_exhausted", 296'(user_tx_ready), 296'(0));
    user_tx_valid = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
